// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Port indices into the packed request/grant vectors
  localparam int PORT_C = 0;
  localparam int PORT_D = 1;

  // Lock ownership state; the owner is encoded in the state itself
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED_C = 2'd1,
    LOCKED_D = 2'd2
  } arb_state_e;

  // Map a winning port index to the locked state it would enter
  function automatic arb_state_e lock_state_of(input logic port);
    return port ? LOCKED_D : LOCKED_C;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's handshake and data bundle toward the arbiter.
// The requester side is the master; the arbiter side is the slave.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_arb2_pick.sv
// Combinational two-way picker: honours an active lock owner, otherwise
// resolves ties by round-robin or fixed priority toward port c.
module arb2_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       prio_mode,
  input  arb_state_e lock_owner,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    case (lock_owner)
      LOCKED_C: gnt[PORT_C] = 1'b1;
      LOCKED_D: gnt[PORT_D] = 1'b1;
      default: begin
        if (req[PORT_C] && req[PORT_D]) begin
          // Round-robin hands the tie to whoever did not win last
          if (prio_mode || (last_gnt == 1'(PORT_D))) begin
            gnt[PORT_C] = 1'b1;
          end else begin
            gnt[PORT_D] = 1'b1;
          end
        end else begin
          gnt = req;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word-addressed data memory between the core (c)
// and a debug/loader port (d). Grants are combinational, writes commit at
// the granting edge, reads return one cycle later in a per-port register.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PRIO_MODE = 0,
  parameter int LOCK_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     c,
  dmem_arbiter_if.slave     d,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_WE,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD,
  output logic              lock_to
);

  localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              lock_to_q, lock_to_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0]        req_v;
  logic [1:0]        lock_v;
  logic [1:0]        we_v;
  logic              held;
  arb_state_e        hold_owner;
  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              win_port;

  // Decide whether the current lock owner still keeps the memory this cycle
  always_comb begin
    req_v      = {d.req, c.req};
    lock_v     = {d.lock, c.lock};
    we_v       = {d.we, c.we};
    held       = 1'b0;
    hold_owner = UNLOCKED;
    if ((state_q == LOCKED_C) && c.req && c.lock) begin
      held       = 1'b1;
      hold_owner = LOCKED_C;
    end else if ((state_q == LOCKED_D) && d.req && d.lock) begin
      held       = 1'b1;
      hold_owner = LOCKED_D;
    end
  end

  arb2_pick u_pick (
    .req        (req_v),
    .last_gnt   (last_gnt_q),
    .prio_mode  (PRIO_MODE != 0),
    .lock_owner (hold_owner),
    .gnt        (pick_gnt)
  );

  // State, lock counter, last winner and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      last_gnt_q <= 1'(PORT_D);
      lock_to_q  <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_gnt_q <= last_gnt_d;
      lock_to_q  <= lock_to_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next lock state: continue, time out, acquire, or fall back to unlocked
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    lock_to_d  = 1'b0;
    if (held) begin
      last_gnt_d = win_port;
      if (lock_cnt_q >= (CNT_MAX - 1'b1)) begin
        // This grant uses up the lock budget; release and flag it next cycle
        state_d    = UNLOCKED;
        lock_cnt_d = '0;
        lock_to_d  = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (|gnt) begin
      last_gnt_d = win_port;
      if (lock_v[win_port]) begin
        state_d    = lock_state_of(win_port);
        lock_cnt_d = CNT_W'(1);
      end else begin
        state_d    = UNLOCKED;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = UNLOCKED;
      lock_cnt_d = '0;
    end
  end

  // Grants, memory drive and read-capture values
  always_comb begin
    gnt        = rst_n ? pick_gnt : 2'b00;
    win_port   = gnt[PORT_D];
    mem_A      = gnt[PORT_D] ? d.addr  : c.addr;
    mem_WD     = gnt[PORT_D] ? d.wdata : c.wdata;
    mem_WE     = |(gnt & we_v);
    c_rvalid_d = gnt[PORT_C] & ~c.we;
    d_rvalid_d = gnt[PORT_D] & ~d.we;
    c_rdata_d  = c_rvalid_d ? mem_RD : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_RD : d_rdata_q;
  end

  assign c.gnt    = gnt[PORT_C];
  assign d.gnt    = gnt[PORT_D];
  assign c.rvalid = c_rvalid_q;
  assign d.rvalid = d_rvalid_q;
  assign c.rdata  = c_rdata_q;
  assign d.rdata  = d_rdata_q;
  assign lock_to  = lock_to_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word-addressed data memory between two requesters: the MIPS core load/store path (port c) and a debug/loader port (port d).
- Drives the memory address, write-enable and write-data inputs, and returns read data one cycle after grant.
- Arbitration is round-robin or fixed-priority, with bounded lock support for read-modify-write sequences.

Parameters:
- ADDR_W, 32, address width (word address, passed through unchanged).
- DATA_W, 32, data width.
- PRIO_MODE, 0, 0 = round-robin on tie; 1 = port c always wins on tie.
- LOCK_MAX, 4, maximum consecutive grants to a locked owner (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- c_req  in  1  core access request.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_lock  in  1  core requests consecutive grants.
- c_gnt  out  1  core access performed this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- d_req, d_we, d_addr, d_wdata, d_lock, d_gnt, d_rvalid, d_rdata: same as the c_* ports, for the debug/loader port.
- mem_A  out  ADDR_W  to memory A.
- mem_WE  out  1  to memory WE.
- mem_WD  out  DATA_W  to memory WD.
- mem_RD  in  DATA_W  from memory RD (combinational read).
- lock_to  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - c_rvalid, d_rvalid, lock_to = 0; c_rdata, d_rdata = 0.
  - State = UNLOCKED; lock_cnt = 0; last_gnt = d, so the core wins the first tie.
  - While rst_n=0: c_gnt = d_gnt = 0 and mem_WE = 0.
- Grant is combinational from req and registered state; at most one gnt per cycle. A request is held by the requester until its gnt is seen.
- Memory drive:
  - mem_A and mem_WD mux from the granted port; the port is c when no grant.
  - mem_WE = granted port's we & gnt; the write commits at the same clk edge.
  - Idle cycles: mem_WE = 0.
- Read latency 1:
  - A granted read in cycle N captures mem_RD into x_rdata at the edge ending N; x_rvalid = 1 in cycle N+1 only.
  - Writes never assert rvalid.
  - x_rdata holds its value until the next read by that port.
- UNLOCKED state:
  - Only one requester: that port is granted.
  - Both requesting, PRIO_MODE=0: grant the port != last_gnt.
  - Both requesting, PRIO_MODE=1: grant c.
  - last_gnt updates to the winner.
  - If the winner has lock=1: next state is LOCKED_C or LOCKED_D, and lock_cnt = 1.
- LOCKED_x state:
  - If owner req=1 and lock=1: grant owner only; the other port waits; lock_cnt increments.
  - If owner drops req or lock: the cycle is arbitrated as UNLOCKED (other port may be granted that same cycle); state returns to UNLOCKED.
  - When a grant makes lock_cnt reach LOCK_MAX: the next state is UNLOCKED; lock_to pulses in the following cycle; last_gnt = owner.
  - Relock by the same owner is allowed only by normal arbitration.
- lock_cnt saturates at LOCK_MAX; it is cleared on entry to UNLOCKED.
- Reset mid-lock: immediate return to reset values; pending rvalid is suppressed.
- Address wrap-around is not the arbiter's concern: addresses are passed through unchanged.

Decomposition:
- Package dmem_arb_pkg: owner/state enum (UNLOCKED, LOCKED_C, LOCKED_D), port index constants (PORT_C=0, PORT_D=1), default widths.
- One sub-module, arb2_pick: combinational 2-way picker (req[1:0], last_gnt, prio_mode, lock_owner -> one-hot gnt). The top level holds state, counters, muxes and response registers.

Test Plan:
- c writes addr 5 = 0x11; next cycle c reads addr 5 -> c_gnt each cycle; c_rvalid=1 and c_rdata=0x11 exactly one cycle after the read grant; d_rvalid stays 0.
- c and d both req every cycle (reads at addrs 1/2), PRIO_MODE=0, after reset -> grants alternate c, d, c, d; first grant is c.
- Same stimulus with PRIO_MODE=1 -> c_gnt=1 every cycle; d_gnt=0 until c_req drops, then d_gnt=1 in that same cycle.
- c holds lock=1 and req=1 while d requests, LOCK_MAX=4 -> c granted 4 consecutive cycles; lock_to=1 in the cycle after the 4th grant; d granted in that cycle.
- c locked, drops lock after 2 grants while d requesting -> d granted in the cycle c_lock=0; no lock_to pulse.
- rst_n=0 for one cycle during LOCKED_C with a read just granted -> next cycle: c_rvalid=0, lock_to=0, both gnt=0, mem_WE=0; after release, a tie goes to c.
